// File: rtl/bch_dec_serial.sv
// Bit-serial single-error-correcting decoder for the 141-bit systematic codeword.
// Syndrome is c(x) mod g(x) computed MSB first; a locator walk over x^k finds the error bit.
module bch_dec_serial #(
  parameter int N = 141,
  parameter int K = 127,
  parameter logic [N-K:0] GPOLY = 15'h4443
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] IN,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] OUT,
  output logic         err_corrected,
  output logic         err_uncorrectable
);

  localparam int P  = N - K;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SYND, SEARCH, DONE} state_t;

  state_t          state, state_next;
  logic [N-1:0]    cw_reg;
  logic [N-1:0]    cw_flip;
  logic [P-1:0]    rem, rem_next;
  logic [P-1:0]    loc, loc_next;
  logic [CW-1:0]   cnt;
  logic [P:0]      t;
  logic            match;
  logic            last;

  always_comb begin
    t = {rem, cw_reg[cnt]};
    if (t[P]) t = t ^ GPOLY;
    rem_next = t[P-1:0];
    loc_next = {loc[P-2:0], 1'b0} ^ (loc[P-1] ? GPOLY[P-1:0] : '0);
    match    = (loc == rem);
    last     = (cnt == CW'(N - 1));
    cw_flip      = cw_reg;
    cw_flip[cnt] = ~cw_reg[cnt];
  end

  always_comb begin
    state_next = state;
    in_ready   = (state == IDLE);
    out_valid  = (state == DONE);
    case (state)
      IDLE:    if (in_valid) state_next = SYND;
      SYND:    if (cnt == '0) state_next = (rem_next == '0) ? DONE : SEARCH;
      SEARCH:  if (match || last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // cnt is the bit index b while dividing (counts down) and the locator exponent k while searching (counts up)
  always_ff @(posedge clk) begin
    if (reset) begin
      cw_reg            <= '0;
      rem               <= '0;
      loc               <= '0;
      cnt               <= '0;
      OUT               <= '0;
      err_corrected     <= 1'b0;
      err_uncorrectable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cw_reg <= IN;
            rem    <= '0;
            cnt    <= CW'(N - 1);
          end
        end
        SYND: begin
          rem <= rem_next;
          if (cnt == '0) begin
            loc <= P'(1);
            if (rem_next == '0) OUT <= cw_reg[N-1:N-K];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SEARCH: begin
          if (match) begin
            cw_reg        <= cw_flip;
            OUT           <= cw_flip[N-1:N-K];
            err_corrected <= 1'b1;
          end else if (last) begin
            OUT               <= cw_reg[N-1:N-K];
            err_uncorrectable <= 1'b1;
          end else begin
            loc <= loc_next;
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            err_corrected     <= 1'b0;
            err_uncorrectable <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_dec_serial.sv
// Directed bench for bch_dec_serial: vector table, single-error sweep, stall and mid-search reset.
module tb_bch_dec_serial;

  localparam int N = 141;
  localparam int K = 127;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] IN;
  logic         out_valid;
  logic         out_ready;
  logic [K-1:0] OUT;
  logic         err_corrected;
  logic         err_uncorrectable;

  int errors = 0;
  int checks = 0;

  logic [13:0] pw [0:N-1];

  typedef struct {
    logic [N-1:0] cw;
    logic [K-1:0] dout;
    logic         corr;
    logic         unc;
    int           lat;
  } vec_t;

  vec_t tv [6];

  bch_dec_serial dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .IN(IN),
    .out_valid(out_valid), .out_ready(out_ready), .OUT(OUT),
    .err_corrected(err_corrected), .err_uncorrectable(err_uncorrectable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] encode(input logic [K-1:0] d);
    logic [13:0] p = '0;
    for (int j = 0; j < K; j++)
      if (d[j]) p ^= pw[j + 14];
    return {d, p};
  endfunction

  function automatic logic [K-1:0] rand_data();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[K-1:0];
  endfunction

  task automatic run_word(input logic [N-1:0] cw, output int lat);
    @(negedge clk);
    IN = cw;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_word(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, ".vld_after"}, out_valid, 0);
    chk({name, ".flags_after"}, {err_corrected, err_uncorrectable}, 0);
  endtask

  initial begin
    int lat;
    int hit;
    int seen;
    logic [K-1:0] d;
    logic [13:0]  s;

    pw[0] = 14'h0001;
    for (int i = 1; i < N; i++)
      pw[i] = {pw[i-1][12:0], 1'b0} ^ (pw[i-1][13] ? 14'h0443 : 14'h0000);

    tv[0] = '{cw: '0, dout: '0, corr: 1'b0, unc: 1'b0, lat: 142};
    tv[1] = '{cw: (141'd1 << 14) | 141'h0443, dout: 127'd1, corr: 1'b0, unc: 1'b0, lat: 142};
    tv[2] = '{cw: 141'd1, dout: '0, corr: 1'b1, unc: 1'b0, lat: 143};
    tv[3] = '{cw: 141'd1 << 14, dout: '0, corr: 1'b1, unc: 1'b0, lat: 157};
    d = rand_data();
    tv[4] = '{cw: encode(d), dout: d, corr: 1'b0, unc: 1'b0, lat: 142};
    d = rand_data();
    s = pw[0] ^ pw[1];
    hit = -1;
    for (int i = 0; i < N; i++)
      if (hit < 0 && pw[i] == s) hit = i;
    if (hit < 0)
      tv[5] = '{cw: encode(d) ^ 141'h3, dout: d, corr: 1'b0, unc: 1'b1, lat: 2 * N + 1};
    else
      tv[5] = '{cw: encode(d) ^ 141'h3,
                dout: (hit >= 14) ? (d ^ (127'd1 << (hit - 14))) : d,
                corr: 1'b1, unc: 1'b0, lat: N + 2 + hit};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; IN = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.OUT", OUT, 0);
    chk("rst.flags", {err_corrected, err_uncorrectable}, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_word(tv[v].cw, lat);
      chk($sformatf("vec%0d.lat", v), lat, tv[v].lat);
      chk($sformatf("vec%0d.OUT", v), OUT, tv[v].dout);
      chk($sformatf("vec%0d.corr", v), err_corrected, tv[v].corr);
      chk($sformatf("vec%0d.unc", v), err_uncorrectable, tv[v].unc);
      chk($sformatf("vec%0d.in_ready", v), in_ready, 0);
      release_word($sformatf("vec%0d", v));
    end

    for (int pos = 0; pos < N; pos++) begin
      d = rand_data();
      run_word(encode(d) ^ (141'd1 << pos), lat);
      chk($sformatf("sweep%0d.lat", pos), lat, N + 2 + pos);
      chk($sformatf("sweep%0d.OUT", pos), OUT, d);
      chk($sformatf("sweep%0d.flags", pos), {err_corrected, err_uncorrectable}, 2'b10);
      release_word($sformatf("sweep%0d", pos));
    end

    d = rand_data();
    run_word(encode(d) ^ (141'd1 << 30), lat);
    chk("stall.lat", lat, N + 2 + 30);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d", c), {out_valid, in_ready, err_corrected, err_uncorrectable, OUT},
          {1'b1, 1'b0, 1'b1, 1'b0, d});
    end
    release_word("stall");

    @(negedge clk);
    IN = 141'd1 << 140;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (N + 50) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst.in_ready", in_ready, 1);
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.flags", {err_corrected, err_uncorrectable}, 0);
    chk("midrst.OUT", OUT, 0);
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst.no_output", seen, 0);

    d = rand_data();
    run_word(encode(d), lat);
    chk("recover.lat", lat, 142);
    chk("recover.OUT", OUT, d);
    release_word("recover");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
